// File: rtl/instr_encoder_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder_loader_pkg
// Description : Shared instruction-type one-hot codes (inst_* set), MIPS
//               opcode / function constants, IM base address and small
//               word-packing helpers used by the instruction encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_encoder_loader_pkg;

  typedef logic [59:0] itype_t;

  localparam logic [31:0] IM_BASE = 32'h0000_3000;

  // One-hot instruction types; bits 55..59 are unassigned and treated as illegal.
  localparam itype_t INST_ADD   = 60'd1 << 0,  INST_ADDU  = 60'd1 << 1,  INST_SUB   = 60'd1 << 2;
  localparam itype_t INST_SUBU  = 60'd1 << 3,  INST_AND   = 60'd1 << 4,  INST_OR    = 60'd1 << 5;
  localparam itype_t INST_XOR   = 60'd1 << 6,  INST_NOR   = 60'd1 << 7,  INST_SLT   = 60'd1 << 8;
  localparam itype_t INST_SLTU  = 60'd1 << 9,  INST_SLL   = 60'd1 << 10, INST_SRL   = 60'd1 << 11;
  localparam itype_t INST_SRA   = 60'd1 << 12, INST_SLLV  = 60'd1 << 13, INST_SRLV  = 60'd1 << 14;
  localparam itype_t INST_SRAV  = 60'd1 << 15, INST_JR    = 60'd1 << 16, INST_JALR  = 60'd1 << 17;
  localparam itype_t INST_MFHI  = 60'd1 << 18, INST_MFLO  = 60'd1 << 19, INST_MTHI  = 60'd1 << 20;
  localparam itype_t INST_MTLO  = 60'd1 << 21, INST_MULT  = 60'd1 << 22, INST_MULTU = 60'd1 << 23;
  localparam itype_t INST_DIV   = 60'd1 << 24, INST_DIVU  = 60'd1 << 25, INST_ORI   = 60'd1 << 26;
  localparam itype_t INST_ANDI  = 60'd1 << 27, INST_XORI  = 60'd1 << 28, INST_LUI   = 60'd1 << 29;
  localparam itype_t INST_ADDI  = 60'd1 << 30, INST_ADDIU = 60'd1 << 31, INST_SLTI  = 60'd1 << 32;
  localparam itype_t INST_SLTIU = 60'd1 << 33, INST_LB    = 60'd1 << 34, INST_LBU   = 60'd1 << 35;
  localparam itype_t INST_LH    = 60'd1 << 36, INST_LHU   = 60'd1 << 37, INST_LW    = 60'd1 << 38;
  localparam itype_t INST_SB    = 60'd1 << 39, INST_SH    = 60'd1 << 40, INST_SW    = 60'd1 << 41;
  localparam itype_t INST_BEQ   = 60'd1 << 42, INST_BNE   = 60'd1 << 43, INST_BGTZ  = 60'd1 << 44;
  localparam itype_t INST_BLEZ  = 60'd1 << 45, INST_BGEZ  = 60'd1 << 46, INST_BLTZ  = 60'd1 << 47;
  localparam itype_t INST_J     = 60'd1 << 48, INST_JAL   = 60'd1 << 49, INST_MTC0  = 60'd1 << 50;
  localparam itype_t INST_MFC0  = 60'd1 << 51, INST_ERET  = 60'd1 << 52, INST_SYSCALL = 60'd1 << 53;
  localparam itype_t INST_ERR   = 60'd1 << 54;

  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02, OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04, OP_BNE    = 6'h05, OP_BLEZ  = 6'h06, OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08, OP_ADDIU  = 6'h09, OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C, OP_ORI    = 6'h0D, OP_XORI  = 6'h0E, OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_COP0    = 6'h10, OP_LB     = 6'h20, OP_LH    = 6'h21, OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24, OP_LHU    = 6'h25, OP_SB    = 6'h28, OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL   = 6'h02, FN_SRA  = 6'h03, FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06, FN_SRAV  = 6'h07, FN_JR   = 6'h08, FN_JALR  = 6'h09;
  localparam logic [5:0] FN_SYSCALL = 6'h0C, FN_MFHI = 6'h10, FN_MTHI = 6'h11, FN_MFLO = 6'h12;
  localparam logic [5:0] FN_MTLO = 6'h13, FN_MULT  = 6'h18, FN_MULTU = 6'h19, FN_DIV  = 6'h1A;
  localparam logic [5:0] FN_DIVU = 6'h1B, FN_ADD   = 6'h20, FN_ADDU = 6'h21, FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23, FN_AND   = 6'h24, FN_OR   = 6'h25, FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27, FN_SLT   = 6'h2A, FN_SLTU = 6'h2B, FN_ERET  = 6'h18;

  // REGIMM rt selector and COP0 rs selector values.
  localparam logic [4:0] RT_BGEZ = 5'b00001, RT_BLTZ = 5'b00000;
  localparam logic [4:0] CP0_MT  = 5'b00100, CP0_MF  = 5'b00000;

  function automatic logic [31:0] r_word(input logic [5:0] fn, input logic [4:0] s, t, d, sh);
    return {OP_SPECIAL, s, t, d, sh, fn};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] s, t,
                                         input logic [15:0] imm);
    return {op, s, t, imm};
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_encoder_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder_loader_if
// Description : Request channel (valid/ready + instruction fields) and
//               instruction-memory write channel (we/addr/wdata/ready).
//               master = request source / IM sink side, slave = loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_encoder_loader_if;
  import instr_encoder_loader_pkg::*;

  logic        in_valid;
  logic        in_ready;
  itype_t      InstrType;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [15:0] imm16;
  logic [25:0] target26;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;
  logic        im_ready;

  modport master (
    output in_valid, InstrType, rs, rt, rd, shamt, imm16, target26, im_ready,
    input  in_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    input  in_valid, InstrType, rs, rt, rd, shamt, imm16, target26, im_ready,
    output in_ready, im_we, im_addr, im_wdata
  );
endinterface
`default_nettype wire

// File: rtl/instr_encoder_loader_instr_word_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_word_encoder
// Description : Combinational MIPS encoder. Maps a one-hot instruction type
//               plus operand fields to a 32-bit word. Any type that is not
//               exactly one of the known codes (zero, multi-hot, unassigned
//               bit or INST_ERR) raises illegal with word = 0.
// Ports       : instr_type, rs, rt, rd, shamt, imm16, target26 (in);
//               word, illegal (out)
// Revision    : 1.0 - initial release
// ============================================================================
module instr_word_encoder
  import instr_encoder_loader_pkg::*;
(
  input  itype_t      instr_type,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm16,
  input  logic [25:0] target26,
  output logic [31:0] word,
  output logic        illegal
);

  // Full-width equality against each code doubles as the one-hot check.
  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (instr_type)
      INST_ADD:     word = r_word(FN_ADD,  rs, rt, rd, shamt);
      INST_ADDU:    word = r_word(FN_ADDU, rs, rt, rd, shamt);
      INST_SUB:     word = r_word(FN_SUB,  rs, rt, rd, shamt);
      INST_SUBU:    word = r_word(FN_SUBU, rs, rt, rd, shamt);
      INST_AND:     word = r_word(FN_AND,  rs, rt, rd, shamt);
      INST_OR:      word = r_word(FN_OR,   rs, rt, rd, shamt);
      INST_XOR:     word = r_word(FN_XOR,  rs, rt, rd, shamt);
      INST_NOR:     word = r_word(FN_NOR,  rs, rt, rd, shamt);
      INST_SLT:     word = r_word(FN_SLT,  rs, rt, rd, shamt);
      INST_SLTU:    word = r_word(FN_SLTU, rs, rt, rd, shamt);
      INST_JALR:    word = r_word(FN_JALR, rs, rt, rd, shamt);
      INST_SLL:     word = r_word(FN_SLL,  5'd0, rt, rd, shamt);
      INST_SRL:     word = r_word(FN_SRL,  5'd0, rt, rd, shamt);
      INST_SRA:     word = r_word(FN_SRA,  5'd0, rt, rd, shamt);
      INST_SLLV:    word = r_word(FN_SLLV, rs, rt, rd, 5'd0);
      INST_SRLV:    word = r_word(FN_SRLV, rs, rt, rd, 5'd0);
      INST_SRAV:    word = r_word(FN_SRAV, rs, rt, rd, 5'd0);
      INST_JR:      word = r_word(FN_JR,   rs, 5'd0, 5'd0, 5'd0);
      INST_MTHI:    word = r_word(FN_MTHI, rs, 5'd0, 5'd0, 5'd0);
      INST_MTLO:    word = r_word(FN_MTLO, rs, 5'd0, 5'd0, 5'd0);
      INST_MFHI:    word = r_word(FN_MFHI, 5'd0, 5'd0, rd, shamt);
      INST_MFLO:    word = r_word(FN_MFLO, 5'd0, 5'd0, rd, shamt);
      INST_MULT:    word = r_word(FN_MULT,  rs, rt, 5'd0, 5'd0);
      INST_MULTU:   word = r_word(FN_MULTU, rs, rt, 5'd0, 5'd0);
      INST_DIV:     word = r_word(FN_DIV,   rs, rt, 5'd0, 5'd0);
      INST_DIVU:    word = r_word(FN_DIVU,  rs, rt, 5'd0, 5'd0);
      INST_SYSCALL: word = r_word(FN_SYSCALL, 5'd0, 5'd0, 5'd0, 5'd0);
      INST_ORI:     word = i_word(OP_ORI,   rs, rt, imm16);
      INST_ANDI:    word = i_word(OP_ANDI,  rs, rt, imm16);
      INST_XORI:    word = i_word(OP_XORI,  rs, rt, imm16);
      INST_LUI:     word = i_word(OP_LUI,   5'd0, rt, imm16);
      INST_ADDI:    word = i_word(OP_ADDI,  rs, rt, imm16);
      INST_ADDIU:   word = i_word(OP_ADDIU, rs, rt, imm16);
      INST_SLTI:    word = i_word(OP_SLTI,  rs, rt, imm16);
      INST_SLTIU:   word = i_word(OP_SLTIU, rs, rt, imm16);
      INST_LB:      word = i_word(OP_LB,    rs, rt, imm16);
      INST_LBU:     word = i_word(OP_LBU,   rs, rt, imm16);
      INST_LH:      word = i_word(OP_LH,    rs, rt, imm16);
      INST_LHU:     word = i_word(OP_LHU,   rs, rt, imm16);
      INST_LW:      word = i_word(OP_LW,    rs, rt, imm16);
      INST_SB:      word = i_word(OP_SB,    rs, rt, imm16);
      INST_SH:      word = i_word(OP_SH,    rs, rt, imm16);
      INST_SW:      word = i_word(OP_SW,    rs, rt, imm16);
      INST_BEQ:     word = i_word(OP_BEQ,   rs, rt, imm16);
      INST_BNE:     word = i_word(OP_BNE,   rs, rt, imm16);
      INST_BGTZ:    word = i_word(OP_BGTZ,  rs, 5'd0, imm16);
      INST_BLEZ:    word = i_word(OP_BLEZ,  rs, 5'd0, imm16);
      INST_BGEZ:    word = i_word(OP_REGIMM, rs, RT_BGEZ, imm16);
      INST_BLTZ:    word = i_word(OP_REGIMM, rs, RT_BLTZ, imm16);
      INST_J:       word = {OP_J,   target26};
      INST_JAL:     word = {OP_JAL, target26};
      INST_MTC0:    word = {OP_COP0, CP0_MT, rt, rd, 11'b0};
      INST_MFC0:    word = {OP_COP0, CP0_MF, rt, rd, 11'b0};
      INST_ERET:    word = {OP_COP0, 1'b1, 19'b0, FN_ERET};
      INST_ERR:     illegal = 1'b1;
      default:      illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder_loader
// Description : Encodes instruction requests into MIPS words, buffers them
//               in a 4-entry FIFO and drains them into the IM write port at
//               consecutive word addresses starting at BASE_ADDR.
// Ports       : clk, reset (async, active-low), flush (sync clear);
//               bus (slave): request channel and IM write channel;
//               err (pulse), err_cnt (saturating), wrapped (sticky),
//               count (FIFO occupancy 0..4)
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = IM_BASE,
  parameter int          IM_WORDS  = 4096
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  instr_encoder_loader_if.slave        bus,
  output logic                         err,
  output logic [7:0]                   err_cnt,
  output logic                         wrapped,
  output logic [2:0]                   count
);

  localparam int IDX_W = (IM_WORDS > 1) ? $clog2(IM_WORDS) : 1;

  logic [31:0]      w_word;
  logic             w_illegal;
  logic             w_empty, w_full, w_accept, w_push, w_pop;

  logic [31:0]      r_mem [4];
  logic [1:0]       r_wr_ptr, r_rd_ptr;
  logic [2:0]       r_count;
  logic [IDX_W-1:0] r_idx;
  logic             r_err, r_wrapped;
  logic [7:0]       r_err_cnt;

  instr_word_encoder u_enc (
    .instr_type (bus.InstrType),
    .rs         (bus.rs),
    .rt         (bus.rt),
    .rd         (bus.rd),
    .shamt      (bus.shamt),
    .imm16      (bus.imm16),
    .target26   (bus.target26),
    .word       (w_word),
    .illegal    (w_illegal)
  );

  assign w_empty  = (r_count == 3'd0);
  assign w_full   = (r_count == 3'd4);
  // Ready depends only on registered fullness (and flush), never on legality.
  assign bus.in_ready = !w_full && !flush;
  assign w_accept = bus.in_valid && bus.in_ready;
  assign w_push   = w_accept && !w_illegal;
  assign w_pop    = !w_empty && bus.im_ready;

  assign bus.im_we    = !w_empty;
  assign bus.im_addr  = BASE_ADDR + (32'(r_idx) << 2);
  assign bus.im_wdata = w_empty ? 32'd0 : r_mem[r_rd_ptr];

  assign err     = r_err;
  assign err_cnt = r_err_cnt;
  assign wrapped = r_wrapped;
  assign count   = r_count;

  // Storage needs no reset: the head is masked to zero whenever empty.
  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wr_ptr] <= w_word;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_idx     <= '0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
      r_wrapped <= 1'b0;
    end else if (flush) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_idx     <= '0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
      r_wrapped <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
        if (r_idx == IDX_W'(IM_WORDS - 1)) begin
          r_idx     <= '0;
          r_wrapped <= 1'b1;
        end else begin
          r_idx <= r_idx + IDX_W'(1);
        end
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
      r_err <= w_accept && w_illegal;
      if (w_accept && w_illegal && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encoder_loader
// Description : Self-checking bench. A queue-based reference model predicts
//               FIFO contents, write addresses and error flags; expected
//               words come from a per-instruction table of base word plus
//               kept-operand mask.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder_loader;

  localparam logic [31:0] BASE  = 32'h0000_3000;
  localparam int          WORDS = 4;

  localparam int KR = 0, KI = 1, KJ = 2, KN = 3;
  localparam logic [31:0] M_RS = 32'h03E0_0000, M_RT = 32'h001F_0000, M_RD = 32'h0000_F800;
  localparam logic [31:0] M_SH = 32'h0000_07C0, M_IM = 32'h0000_FFFF, M_TG = 32'h03FF_FFFF;
  localparam logic [31:0] M_R4 = M_RS | M_RT | M_RD | M_SH, M_I3 = M_RS | M_RT | M_IM;

  logic       clk = 1'b0;
  logic       reset, flush;
  logic       err, wrapped;
  logic [7:0] err_cnt;
  logic [2:0] count;

  instr_encoder_loader_if bus();

  instr_encoder_loader #(.BASE_ADDR(BASE), .IM_WORDS(WORDS)) dut (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus),
    .err(err), .err_cnt(err_cnt), .wrapped(wrapped), .count(count)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  logic [31:0] base_tbl [55];
  logic [31:0] mask_tbl [55];
  int          kind_tbl [55];

  logic [31:0] q_exp [$];
  int          exp_idx = 0, exp_err_cnt = 0;
  logic        exp_err = 1'b0, exp_wrapped = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tbl(input int i, input logic [31:0] b, input int k, input logic [31:0] m);
    base_tbl[i] = b; kind_tbl[i] = k; mask_tbl[i] = m;
  endtask

  function automatic void model_enc(input logic [59:0] it, output logic [31:0] w, output logic ill);
    int idx;
    logic [31:0] raw;
    ill = 1'b1; w = '0; idx = -1; raw = '0;
    if ($countones(it) == 1)
      for (int b = 0; b < 60; b++) if (it[b]) idx = b;
    if (idx >= 0 && idx < 54) begin
      ill = 1'b0;
      case (kind_tbl[idx])
        KR:      raw = {6'b0, bus.rs, bus.rt, bus.rd, bus.shamt, 6'b0};
        KI:      raw = {6'b0, bus.rs, bus.rt, bus.imm16};
        KJ:      raw = {6'b0, bus.target26};
        default: raw = '0;
      endcase
      w = base_tbl[idx] | (raw & mask_tbl[idx]);
    end
  endfunction

  task automatic drive(input logic v, input logic [59:0] it, input logic [4:0] a, b, c, d,
                       input logic [15:0] imm, input logic [25:0] tg);
    bus.in_valid = v; bus.InstrType = it; bus.rs = a; bus.rt = b; bus.rd = c;
    bus.shamt = d; bus.imm16 = imm; bus.target26 = tg;
  endtask

  task automatic drive_rand(input logic v, input bit legal_only);
    logic [63:0] bits;
    bits = {$urandom, $urandom};
    if (legal_only || $urandom_range(0, 9) != 0) bits = 64'd1 << $urandom_range(0, 53);
    drive(v, bits[59:0], 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
          16'($urandom), 26'($urandom));
  endtask

  task automatic model_clear();
    q_exp.delete(); exp_idx = 0; exp_wrapped = 1'b0; exp_err = 1'b0; exp_err_cnt = 0;
  endtask

  // Checks outputs mid-cycle, then advances the model across the next edge.
  task automatic tick();
    logic acc, ill, pop;
    logic [31:0] w;
    @(negedge clk);
    chk("count",    64'(count),         64'(q_exp.size()));
    chk("in_ready", 64'(bus.in_ready),  64'((q_exp.size() < 4) && !flush));
    chk("im_we",    64'(bus.im_we),     64'(q_exp.size() != 0));
    chk("err",      64'(err),           64'(exp_err));
    chk("err_cnt",  64'(err_cnt),       64'(exp_err_cnt));
    chk("wrapped",  64'(wrapped),       64'(exp_wrapped));
    if (q_exp.size() != 0) begin
      chk("im_wdata", 64'(bus.im_wdata), 64'(q_exp[0]));
      chk("im_addr",  64'(bus.im_addr),  64'(BASE + 32'(4 * exp_idx)));
    end
    acc = bus.in_valid && (q_exp.size() < 4) && !flush;
    pop = (q_exp.size() != 0) && bus.im_ready;
    model_enc(bus.InstrType, w, ill);
    if (flush) begin
      model_clear();
    end else begin
      if (pop) begin
        void'(q_exp.pop_front());
        if (exp_idx == WORDS - 1) begin exp_idx = 0; exp_wrapped = 1'b1; end
        else exp_idx++;
      end
      if (acc && !ill) q_exp.push_back(w);
      exp_err = acc && ill;
      if (acc && ill && exp_err_cnt < 255) exp_err_cnt++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    // ADD..SLTU, shifts, jr/jalr, hi/lo, mult/div
    tbl(0, 32'h20, KR, M_R4); tbl(1, 32'h21, KR, M_R4); tbl(2, 32'h22, KR, M_R4);
    tbl(3, 32'h23, KR, M_R4); tbl(4, 32'h24, KR, M_R4); tbl(5, 32'h25, KR, M_R4);
    tbl(6, 32'h26, KR, M_R4); tbl(7, 32'h27, KR, M_R4); tbl(8, 32'h2A, KR, M_R4);
    tbl(9, 32'h2B, KR, M_R4);
    tbl(10, 32'h00, KR, M_RT | M_RD | M_SH); tbl(11, 32'h02, KR, M_RT | M_RD | M_SH);
    tbl(12, 32'h03, KR, M_RT | M_RD | M_SH); tbl(13, 32'h04, KR, M_RS | M_RT | M_RD);
    tbl(14, 32'h06, KR, M_RS | M_RT | M_RD); tbl(15, 32'h07, KR, M_RS | M_RT | M_RD);
    tbl(16, 32'h08, KR, M_RS); tbl(17, 32'h09, KR, M_R4);
    tbl(18, 32'h10, KR, M_RD | M_SH); tbl(19, 32'h12, KR, M_RD | M_SH);
    tbl(20, 32'h11, KR, M_RS); tbl(21, 32'h13, KR, M_RS);
    tbl(22, 32'h18, KR, M_RS | M_RT); tbl(23, 32'h19, KR, M_RS | M_RT);
    tbl(24, 32'h1A, KR, M_RS | M_RT); tbl(25, 32'h1B, KR, M_RS | M_RT);
    // I-type ALU, loads, stores, branches
    tbl(26, 32'h3400_0000, KI, M_I3); tbl(27, 32'h3000_0000, KI, M_I3);
    tbl(28, 32'h3800_0000, KI, M_I3); tbl(29, 32'h3C00_0000, KI, M_RT | M_IM);
    tbl(30, 32'h2000_0000, KI, M_I3); tbl(31, 32'h2400_0000, KI, M_I3);
    tbl(32, 32'h2800_0000, KI, M_I3); tbl(33, 32'h2C00_0000, KI, M_I3);
    tbl(34, 32'h8000_0000, KI, M_I3); tbl(35, 32'h9000_0000, KI, M_I3);
    tbl(36, 32'h8400_0000, KI, M_I3); tbl(37, 32'h9400_0000, KI, M_I3);
    tbl(38, 32'h8C00_0000, KI, M_I3); tbl(39, 32'hA000_0000, KI, M_I3);
    tbl(40, 32'hA400_0000, KI, M_I3); tbl(41, 32'hAC00_0000, KI, M_I3);
    tbl(42, 32'h1000_0000, KI, M_I3); tbl(43, 32'h1400_0000, KI, M_I3);
    tbl(44, 32'h1C00_0000, KI, M_RS | M_IM); tbl(45, 32'h1800_0000, KI, M_RS | M_IM);
    tbl(46, 32'h0401_0000, KI, M_RS | M_IM); tbl(47, 32'h0400_0000, KI, M_RS | M_IM);
    // jumps, cop0, eret, syscall
    tbl(48, 32'h0800_0000, KJ, M_TG); tbl(49, 32'h0C00_0000, KJ, M_TG);
    tbl(50, 32'h4080_0000, KR, M_RT | M_RD); tbl(51, 32'h4000_0000, KR, M_RT | M_RD);
    tbl(52, 32'h4200_0018, KN, 32'h0); tbl(53, 32'h0000_000C, KN, 32'h0);

    // Reset state
    reset = 1'b0; flush = 1'b0; bus.im_ready = 1'b0;
    drive(1'b0, '0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_im_we",    64'(bus.im_we),    64'd0);
    chk("rst_im_addr",  64'(bus.im_addr),  64'(BASE));
    chk("rst_im_wdata", 64'(bus.im_wdata), 64'd0);
    chk("rst_err",      64'(err),          64'd0);
    chk("rst_err_cnt",  64'(err_cnt),      64'd0);
    chk("rst_wrapped",  64'(wrapped),      64'd0);
    chk("rst_count",    64'(count),        64'd0);
    reset = 1'b1;

    // addu rs=1 rt=2 rd=3: visible at the accepting edge, written next edge
    bus.im_ready = 1'b1;
    drive(1'b1, 60'd1 << 1, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0);
    tick();
    chk("addu_wdata", 64'(bus.im_wdata), 64'h0022_1821);
    chk("addu_addr",  64'(bus.im_addr),  64'h3000);
    bus.in_valid = 1'b0;
    tick(); tick();

    // ori then lui from a cleared address counter
    flush = 1'b1; tick(); flush = 1'b0;
    drive(1'b1, 60'd1 << 26, 5'd0, 5'd8, 5'd0, 5'd0, 16'h1234, 26'd0);
    tick();
    chk("ori_wdata", 64'(bus.im_wdata), 64'h3408_1234);
    chk("ori_addr",  64'(bus.im_addr),  64'h3000);
    drive(1'b1, 60'd1 << 29, 5'd0, 5'd9, 5'd0, 5'd0, 16'hABCD, 26'd0);
    tick();
    chk("lui_wdata", 64'(bus.im_wdata), 64'h3C09_ABCD);
    chk("lui_addr",  64'(bus.im_addr),  64'h3004);
    bus.in_valid = 1'b0;
    tick(); tick();

    // Back-pressure: five requests with IM stalled, then drain in order
    bus.im_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin drive_rand(1'b1, 1'b1); tick(); end
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    chk("full_count",    64'(count),        64'd4);
    bus.in_valid = 1'b0; bus.im_ready = 1'b1;
    repeat (5) tick();

    // Illegal requests: zero type, then two bits set
    flush = 1'b1; tick(); flush = 1'b0;
    drive(1'b1, 60'd0, 5'd1, 5'd1, 5'd1, 5'd1, 16'd1, 26'd1); tick();
    drive(1'b1, 60'h3, 5'd1, 5'd1, 5'd1, 5'd1, 16'd1, 26'd1); tick();
    bus.in_valid = 1'b0;
    tick(); tick();
    chk("illegal_cnt", 64'(err_cnt), 64'd2);

    // Five eret words: address wraps after the fourth write
    flush = 1'b1; tick(); flush = 1'b0;
    drive(1'b1, 60'd1 << 52, 5'd3, 5'd3, 5'd3, 5'd3, 16'h5555, 26'd7);
    repeat (5) tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    chk("eret_wrapped", 64'(wrapped), 64'd1);

    // Flush with a valid request: not accepted
    drive(1'b1, 60'd1 << 26, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0F0F, 26'd0);
    flush = 1'b1; tick(); flush = 1'b0;
    bus.in_valid = 1'b0; tick();

    // err_cnt saturation with inst_err requests
    drive(1'b1, 60'd1 << 54, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
    repeat (260) tick();
    bus.in_valid = 1'b0; tick();
    chk("err_cnt_sat", 64'(err_cnt), 64'd255);
    flush = 1'b1; tick(); flush = 1'b0;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive_rand(1'($urandom_range(0, 1)), 1'b0);
      bus.im_ready = 1'($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 39) == 0);
      tick();
    end
    flush = 1'b0;

    // Asynchronous reset with three words queued
    flush = 1'b1; tick(); flush = 1'b0;
    bus.im_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin drive_rand(1'b1, 1'b1); tick(); end
    chk("pre_rst_count", 64'(count), 64'd3);
    bus.in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("arst_im_we",   64'(bus.im_we),   64'd0);
    chk("arst_count",   64'(count),       64'd0);
    chk("arst_im_addr", 64'(bus.im_addr), 64'(BASE));
    model_clear();
    #2 reset = 1'b1;
    @(posedge clk); #1;
    bus.im_ready = 1'b1;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
